// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit with a two-entry fetched-instruction buffer.
//
// Keeps the fetch PC, issues one instruction-memory request at a time, and
// queues returned words (with their addresses) for decode. A redirect from
// decode flushes the buffer, retargets the PC and discards any response
// that is still in flight.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   redirect_valid, redirect_pc taken branch/jump target (low 2 bits ignored)
//   pc                          current fetch PC
//   imem_req, imem_addr         memory request (held stable until granted)
//   imem_gnt                    request accepted when imem_req && imem_gnt
//   imem_rvalid, imem_rdata     read response, at least one cycle after grant
//   id_valid, id_instr, id_pc   head of the fetched-instruction buffer
//   id_ready                    decode consumes head when id_valid && id_ready
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam logic [1:0] S_REQ  = 2'd0;  // request asserted, awaiting grant
  localparam logic [1:0] S_WAIT = 2'd1;  // granted, awaiting rvalid
  localparam logic [1:0] S_DROP = 2'd2;  // awaiting rvalid to be discarded
  localparam logic [1:0] S_HOLD = 2'd3;  // no request, buffer space insufficient

  // The buffer is two entries, so single-bit pointers suffice.
  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] req_addr;
  logic [31:0] redirect_aligned;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        grant;
  logic        push;
  logic        pop;
  logic        space;

  assign redirect_aligned = redirect_pc & ~32'h3;

  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc & ~32'h3;
  assign grant     = imem_req && imem_gnt;

  assign id_valid = (count != 2'd0);
  assign id_instr = fifo_instr[rd_ptr];
  assign id_pc    = fifo_pc[rd_ptr];

  // A redirect voids both the decode handshake and any arriving data.
  assign pop  = id_valid && id_ready && !redirect_valid;
  assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;

  // Occupancy after this edge. Requests are only raised from REQ, and REQ is
  // only entered when this is below the depth, so nothing is outstanding
  // whenever the check is made and the space rule reduces to this compare.
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign space     = (count_nxt < DEPTH);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (redirect_valid)  state_nxt = grant ? S_DROP : S_REQ;
        else if (grant)      state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) state_nxt = S_REQ;
          else                state_nxt = space ? S_REQ : S_HOLD;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid || space) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC & ~32'h3;
      req_addr      <= '0;
      count         <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_instr[0] <= '0;
      fifo_instr[1] <= '0;
      fifo_pc[0]    <= '0;
      fifo_pc[1]    <= '0;
    end else begin
      state <= state_nxt;

      if (redirect_valid) pc <= redirect_aligned;
      else if (grant)     pc <= pc + 32'd4;

      if (grant) req_addr <= imem_addr;

      if (redirect_valid) begin
        count  <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]    <= req_addr;
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch -- scoreboard bench for ifetch.
//
// A driver process plays the instruction memory and decode stage under
// adjustable probabilities and pushes the expected instruction stream into
// a queue; a separate monitor pops that queue on every decode handshake.
// The expected stream is simply "consecutive words from the last reset or
// redirect target", with each word's content a fixed hash of its address.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned gnt_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned redir_permil = 0;
  int unsigned dmin = 1;
  int unsigned dmax = 1;
  int          redir_mode = 0;   // 1: while a response is pending, 2: with a grant, 3: any cycle
  logic [31:0] redir_tgt = '0;

  logic [31:0] exp_q[$];
  logic [31:0] next_exp = RST_PC;
  logic [31:0] fetch_next = RST_PC;
  int          grants = 0;
  int          n_hs = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    next_exp = a & ~32'h3;
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  // Memory/decode driver and fetch-address model.
  logic        pending = 1'b0;
  logic        fire = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned dly = 0;
  logic        hold_req = 1'b0;
  logic [31:0] hold_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      fire = 1'b0;
      if (pending) begin
        if (dly <= 1) fire = 1'b1;
        else dly--;
      end
      imem_rvalid = fire;
      imem_rdata  = fire ? mem_word(pend_addr) : $urandom;
      if (fire) pending = 1'b0;
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      id_ready       = ($urandom_range(99) < rdy_pct);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (redir_mode == 1 && pending && !fire) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        redir_mode     = 0;
      end else if (redir_mode == 2 && imem_req && !rst) begin
        // grant, a stray rvalid and a redirect all in the same cycle
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        redir_mode     = 0;
      end else if (redir_mode == 3 && !rst) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        redir_mode     = 0;
      end else if (!rst && $urandom_range(999) < redir_permil) begin
        redirect_valid = 1'b1;
      end
      #1;
      if (!rst && hold_req) begin
        check("req_stable", 32'(imem_req), 32'd1);
        check("addr_stable", imem_addr, hold_addr);
      end
      hold_req  = !rst && imem_req && !imem_gnt && !redirect_valid;
      hold_addr = imem_addr;
      if (rst) begin
        restart(RST_PC);
        fetch_next = RST_PC;
        grants = 0;
      end else begin
        if (imem_req && imem_gnt) begin
          check("grant_addr", imem_addr, fetch_next);
          check("one_outstanding", 32'(pending || fire), 32'd0);
          pending   = 1'b1;
          pend_addr = imem_addr;
          dly       = $urandom_range(dmax, dmin);
          grants++;
          fetch_next = fetch_next + 32'd4;
        end
        if (redirect_valid) begin
          fetch_next = redirect_pc & ~32'h3;
          restart(redirect_pc);
        end
      end
      refill();
    end
  end

  // Monitor: pops the expected stream on each decode handshake.
  logic        hold_id = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;
  logic [31:0] e;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && hold_id) begin
        check("head_valid", 32'(id_valid), 32'd1);
        check("head_pc", id_pc, hold_pc);
        check("head_instr", id_instr, hold_instr);
      end
      hold_id    = !rst && id_valid && !id_ready && !redirect_valid;
      hold_pc    = id_pc;
      hold_instr = id_instr;
      if (!rst && id_valid && id_ready && !redirect_valid) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL id_pc: got %h with no expected entry", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, mem_word(e));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_pc", pc, RST_PC);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #4;
    check("req_after_rst", 32'(imem_req), 32'd1);
    check("addr_after_rst", imem_addr, RST_PC);
  endtask

  task automatic redirect_at(input int m, input logic [31:0] t);
    int i;
    redir_tgt  = t;
    redir_mode = m;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      #4;
      if (redir_mode == 0) break;
    end
    check("redirect_issued", 32'(redir_mode), 32'd0);
    redir_mode = 0;
  endtask

  int hs0;

  initial begin
    // Streaming from reset with a one-cycle memory.
    do_reset();
    hs0 = n_hs;
    cycles(20);
    check("stream_progress", 32'(n_hs - hs0 >= 3), 32'd1);

    // Decode stalled: buffer fills to two entries and fetch holds.
    rdy_pct = 0;
    do_reset();
    cycles(12);
    #4;
    check("full_imem_req", 32'(imem_req), 32'd0);
    check("full_id_valid", 32'(id_valid), 32'd1);
    check("full_id_pc", id_pc, RST_PC);
    check("full_id_instr", id_instr, mem_word(RST_PC));
    check("full_grants", 32'(grants), 32'd2);
    rdy_pct = 100;
    hs0 = n_hs;
    cycles(20);
    check("drain_progress", 32'(n_hs - hs0 >= 3), 32'd1);

    // Grant withheld: request and address must not move.
    gnt_pct = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("nogrant_req", 32'(imem_req), 32'd1);
      check("nogrant_addr", imem_addr, RST_PC);
      @(negedge clk);
      #4;
    end
    gnt_pct = 100;
    cycles(10);

    // Redirect while a response is in flight.
    dmin = 3;
    dmax = 3;
    redirect_at(1, 32'h0000_4002);
    @(negedge clk);
    #4;
    check("redir_fifo_empty", 32'(id_valid), 32'd0);
    check("redir_pc", pc, 32'h0000_4000);
    hs0 = n_hs;
    cycles(20);
    check("redir_progress", 32'(n_hs - hs0 >= 2), 32'd1);

    // Redirect coinciding with a grant and a stray response.
    dmin = 1;
    dmax = 1;
    redirect_at(2, 32'h0000_5000);
    cycles(20);

    // Fetch across the top of the address space.
    redirect_at(3, 32'hFFFF_FFF8);
    cycles(20);

    // Randomised traffic, with a reset in the middle.
    gnt_pct = 60;
    rdy_pct = 60;
    dmax = 4;
    redir_permil = 30;
    cycles(1000);
    do_reset();
    hs0 = n_hs;
    cycles(1000);
    check("random_progress", 32'(n_hs - hs0 >= 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
